// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared encodings and helpers for the ARM decode stage
package arm_pkg;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [3:0] PC_IDX = 4'd15;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_ORR = 2'b11
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      IMM_DP  = 2'b00,
      IMM_MEM = 2'b01,
      IMM_BR  = 2'b10
   } imm_src_t;

   // Rotate right by concatenating the word with itself and taking the low half.
   function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
      logic [63:0] w;
      w = {v, v} >> amt;
      return w[31:0];
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch/writeback inputs and decode->execute outputs of the decode stage
interface decode_stage_if;
   logic [31:0] instD;
   logic [31:0] pcPlus8D;
   logic        enableE;
   logic        flushE;
   logic        regWriteW;
   logic [3:0]  wa3W;
   logic [31:0] resultW;

   logic        regWriteE;
   logic        memWriteE;
   logic        memtoRegE;
   logic        pcSrcE;
   logic        branchE;
   logic        aluSrcE;
   logic [1:0]  aluControlE;
   logic [1:0]  flagWriteE;
   logic [3:0]  condE;
   logic [31:0] rd1E;
   logic [31:0] rd2E;
   logic [31:0] extImmE;
   logic [3:0]  wa3E;
   logic [3:0]  ra1E;
   logic [3:0]  ra2E;

   modport master (
      output instD, pcPlus8D, enableE, flushE, regWriteW, wa3W, resultW,
      input  regWriteE, memWriteE, memtoRegE, pcSrcE, branchE, aluSrcE, aluControlE,
             flagWriteE, condE, rd1E, rd2E, extImmE, wa3E, ra1E, ra2E
   );

   modport slave (
      input  instD, pcPlus8D, enableE, flushE, regWriteW, wa3W, resultW,
      output regWriteE, memWriteE, memtoRegE, pcSrcE, branchE, aluSrcE, aluControlE,
             flagWriteE, condE, rd1E, rd2E, extImmE, wa3E, ra1E, ra2E
   );
endinterface

// File: rtl/decode_stage_register_file.sv
// rtl/decode_stage_register_file.sv - 16x32 register file, R15 reads PC+8, write-through bypass
module register_file
   import arm_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_we,
   input  logic [3:0]  i_wa,
   input  logic [31:0] i_wd,
   input  logic [3:0]  i_ra1,
   input  logic [3:0]  i_ra2,
   input  logic [31:0] i_pc8,
   output logic [31:0] o_rd1,
   output logic [31:0] o_rd2
);

   // Entry 15 exists only to keep indexing full-range; it is never written nor read.
   logic [31:0] r_regs [0:15];

   // Storage update: R15 is the PC and is never stored here.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < 16; i++) r_regs[i] <= 32'd0;
      end else if (i_we && (i_wa != PC_IDX)) begin
         r_regs[i_wa] <= i_wd;
      end
   end

   // Read ports: PC index first, then same-cycle writeback bypass, then storage.
   always_comb begin
      o_rd1 = r_regs[i_ra1];
      o_rd2 = r_regs[i_ra2];
      if (i_ra1 == PC_IDX)                      o_rd1 = i_pc8;
      else if (i_we && (i_wa == i_ra1))         o_rd1 = i_wd;
      if (i_ra2 == PC_IDX)                      o_rd2 = i_pc8;
      else if (i_we && (i_wa == i_ra2))         o_rd2 = i_wd;
   end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ARM decode: control decode, register read, immediate extend, D->E register
module decode_stage
   import arm_pkg::*;
(
   input  logic clock,
   input  logic rst,
   decode_stage_if.slave bus
);

   logic [1:0]  w_op;
   logic [5:0]  w_funct;
   logic [3:0]  w_cmd;
   logic        w_s;
   logic        w_reg_write, w_mem_write, w_memto_reg, w_branch, w_alu_src, w_pc_src;
   alu_ctrl_t   w_alu_ctrl;
   logic [1:0]  w_flag_write;
   imm_src_t    w_imm_src;
   logic [31:0] w_ext_imm;
   logic [3:0]  w_ra1, w_ra2;
   logic [31:0] w_rd1, w_rd2;

   logic        r_reg_write, r_mem_write, r_memto_reg, r_pc_src, r_branch, r_alu_src;
   logic [1:0]  r_alu_ctrl, r_flag_write;
   logic [3:0]  r_cond, r_wa3, r_ra1, r_ra2;
   logic [31:0] r_rd1, r_rd2, r_ext_imm;

   assign w_op    = bus.instD[27:26];
   assign w_funct = bus.instD[25:20];
   assign w_cmd   = w_funct[4:1];
   assign w_s     = w_funct[0];

   // Control decode from op/funct; anything unsupported leaves all enables low.
   always_comb begin
      w_reg_write  = 1'b0;
      w_mem_write  = 1'b0;
      w_memto_reg  = 1'b0;
      w_branch     = 1'b0;
      w_alu_src    = 1'b0;
      w_alu_ctrl   = ALU_ADD;
      w_flag_write = 2'b00;
      w_imm_src    = IMM_DP;
      case (w_op)
         OP_DP: begin
            w_alu_src = w_funct[5];
            case (w_cmd)
               CMD_ADD: begin w_alu_ctrl = ALU_ADD; w_reg_write = 1'b1; w_flag_write = {w_s, w_s}; end
               CMD_SUB: begin w_alu_ctrl = ALU_SUB; w_reg_write = 1'b1; w_flag_write = {w_s, w_s}; end
               CMD_AND: begin w_alu_ctrl = ALU_AND; w_reg_write = 1'b1; w_flag_write = {w_s, 1'b0}; end
               CMD_ORR: begin w_alu_ctrl = ALU_ORR; w_reg_write = 1'b1; w_flag_write = {w_s, 1'b0}; end
               CMD_CMP: begin w_alu_ctrl = ALU_SUB; w_flag_write = 2'b11; end
               default: ;
            endcase
         end
         OP_MEM: begin
            w_imm_src = IMM_MEM;
            w_alu_src = 1'b1;
            if (!w_funct[5]) begin
               w_alu_ctrl = w_funct[3] ? ALU_ADD : ALU_SUB;
               if (w_funct[0]) begin
                  w_reg_write = 1'b1;
                  w_memto_reg = 1'b1;
               end else begin
                  w_mem_write = 1'b1;
               end
            end
         end
         OP_BR: begin
            w_imm_src = IMM_BR;
            w_branch  = 1'b1;
            w_alu_src = 1'b1;
         end
         default: ;
      endcase
   end

   // Immediate extension selected by instruction class.
   always_comb begin
      w_ext_imm = 32'd0;
      case (w_imm_src)
         IMM_DP:  w_ext_imm = ror32({24'd0, bus.instD[7:0]}, {bus.instD[11:8], 1'b0});
         IMM_MEM: w_ext_imm = {20'd0, bus.instD[11:0]};
         IMM_BR:  w_ext_imm = {{6{bus.instD[23]}}, bus.instD[23:0], 2'b00};
         default: w_ext_imm = 32'd0;
      endcase
   end

   assign w_ra1    = w_branch ? PC_IDX : bus.instD[19:16];
   assign w_ra2    = w_mem_write ? bus.instD[15:12] : bus.instD[3:0];
   assign w_pc_src = w_reg_write && (bus.instD[15:12] == PC_IDX);

   register_file u_rf (
      .i_clk (clock),
      .i_rst (rst),
      .i_we  (bus.regWriteW),
      .i_wa  (bus.wa3W),
      .i_wd  (bus.resultW),
      .i_ra1 (w_ra1),
      .i_ra2 (w_ra2),
      .i_pc8 (bus.pcPlus8D),
      .o_rd1 (w_rd1),
      .o_rd2 (w_rd2)
   );

   // D->E pipeline register: flush beats stall, stall holds, otherwise load.
   always_ff @(posedge clock or posedge rst) begin
      if (rst || bus.flushE) begin
         r_reg_write  <= 1'b0;
         r_mem_write  <= 1'b0;
         r_memto_reg  <= 1'b0;
         r_pc_src     <= 1'b0;
         r_branch     <= 1'b0;
         r_alu_src    <= 1'b0;
         r_alu_ctrl   <= 2'b00;
         r_flag_write <= 2'b00;
         r_cond       <= 4'd0;
         r_wa3        <= 4'd0;
         r_ra1        <= 4'd0;
         r_ra2        <= 4'd0;
         r_rd1        <= 32'd0;
         r_rd2        <= 32'd0;
         r_ext_imm    <= 32'd0;
      end else if (bus.enableE) begin
         r_reg_write  <= w_reg_write;
         r_mem_write  <= w_mem_write;
         r_memto_reg  <= w_memto_reg;
         r_pc_src     <= w_pc_src;
         r_branch     <= w_branch;
         r_alu_src    <= w_alu_src;
         r_alu_ctrl   <= w_alu_ctrl;
         r_flag_write <= w_flag_write;
         r_cond       <= bus.instD[31:28];
         r_wa3        <= bus.instD[15:12];
         r_ra1        <= w_ra1;
         r_ra2        <= w_ra2;
         r_rd1        <= w_rd1;
         r_rd2        <= w_rd2;
         r_ext_imm    <= w_ext_imm;
      end
   end

   assign bus.regWriteE   = r_reg_write;
   assign bus.memWriteE   = r_mem_write;
   assign bus.memtoRegE   = r_memto_reg;
   assign bus.pcSrcE      = r_pc_src;
   assign bus.branchE     = r_branch;
   assign bus.aluSrcE     = r_alu_src;
   assign bus.aluControlE = r_alu_ctrl;
   assign bus.flagWriteE  = r_flag_write;
   assign bus.condE       = r_cond;
   assign bus.wa3E        = r_wa3;
   assign bus.ra1E        = r_ra1;
   assign bus.ra2E        = r_ra2;
   assign bus.rd1E        = r_rd1;
   assign bus.rd2E        = r_rd2;
   assign bus.extImmE     = r_ext_imm;

endmodule
